// File: rtl/fp32_pkg.sv
// FP32 field layout, operand classes and result flag positions shared by the float-to-int path.
// Also hosts the stage-1 unpack helper so the field slicing lives in one place.
package fp32_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int SIG_W = MAN_W + 1;
    localparam int BIAS  = 127;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORM,
        FP_INF,
        FP_NAN
    } fp_class_t;

    localparam int FLAG_INX = 0;
    localparam int FLAG_OVF = 1;
    localparam int FLAG_INV = 2;
    localparam int FLAG_W   = 3;

    typedef struct packed {
        logic              sign;
        logic signed [8:0] e;
        logic [SIG_W-1:0]  sig;
        fp_class_t         cls;
    } fp_unpacked_t;

    // Zero and subnormal share a class: both truncate to 0, only the inexact flag differs.
    function automatic fp_unpacked_t fp_unpack(input logic [31:0] a);
        fp_unpacked_t     u;
        logic [EXP_W-1:0] ex;
        logic [MAN_W-1:0] man;
        ex     = a[MAN_W +: EXP_W];
        man    = a[MAN_W-1:0];
        u.sign = a[31];
        u.e    = $signed({1'b0, ex}) - 9'(BIAS);
        u.sig  = {(ex != '0), man};
        if (ex == '0) begin
            u.cls = FP_ZERO;
        end else if (ex == EXP_MAX) begin
            u.cls = (man != '0) ? FP_NAN : FP_INF;
        end else begin
            u.cls = FP_NORM;
        end
        return u;
    endfunction

endpackage

// File: rtl/fp_sig_align.sv
// Combinational alignment of a 24b significand to integer weight by unbiased exponent.
// Sticky reports any fraction bit lost by the right shift.
module fp_sig_align
    import fp32_pkg::*;
#(
    parameter int OUT_W = 32
) (
    input  logic [SIG_W-1:0]   i_sig,
    input  logic signed [8:0]  i_e,
    output logic [OUT_W-1:0]   o_mag,
    output logic               o_sticky
);

    localparam logic signed [8:0] E_MAN = 9'(MAN_W);

    logic [8:0]             w_rsh;
    logic [8:0]             w_lsh;
    logic [SIG_W+MAN_W-1:0] w_rext;

    assign w_rsh  = 9'(MAN_W) - $unsigned(i_e);
    assign w_lsh  = $unsigned(i_e) - 9'(MAN_W);
    assign w_rext = {i_sig, {MAN_W{1'b0}}} >> w_rsh;

    always_comb begin
        o_mag    = '0;
        o_sticky = 1'b0;
        if (i_e < 9'sd0) begin
            o_sticky = |i_sig;
        end else if (i_e <= E_MAN) begin
            o_mag    = OUT_W'(w_rext[SIG_W+MAN_W-1:MAN_W]);
            o_sticky = |w_rext[MAN_W-1:0];
        end else begin
            o_mag = OUT_W'({{(64-SIG_W){1'b0}}, i_sig} << w_lsh);
        end
    end

endmodule

// File: rtl/fp32_to_int_pipe.sv
// FP32 -> signed OUT_W integer, truncate toward zero; 2-cycle latency, 1/cycle throughput.
// Valid/ready both sides; a stalled output holds and back-fills stage 1 before o_ready drops.
module fp32_to_int_pipe
    import fp32_pkg::*;
#(
    parameter int OUT_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [31:0]       i_a,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [OUT_W-1:0]  o_z,
    output logic [FLAG_W-1:0] o_flags
);

    localparam logic [OUT_W-1:0]  Z_MAX     = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]  Z_MIN     = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic signed [8:0] E_SAT     = 9'(OUT_W - 2);
    localparam logic signed [8:0] E_NEG_TOP = 9'(OUT_W - 1);

    logic              r_s1_v;
    fp_unpacked_t      r_s1_op;
    logic              r_s2_v;
    logic [OUT_W-1:0]  r_s2_z;
    logic [FLAG_W-1:0] r_s2_flags;

    logic              w_s1_adv;
    logic              w_s2_adv;
    fp_unpacked_t      w_s1_in;
    logic signed [8:0] w_s1_e;
    logic [OUT_W-1:0]  w_mag;
    logic              w_sticky;
    logic [OUT_W-1:0]  w_s2_z;
    logic [FLAG_W-1:0] w_s2_flags;

    assign w_s2_adv = !r_s2_v || i_ready;
    assign w_s1_adv = !r_s1_v || w_s2_adv;
    assign o_ready  = w_s1_adv;
    assign o_valid  = r_s2_v;
    assign o_z      = r_s2_z;
    assign o_flags  = r_s2_flags;

    assign w_s1_in = fp_unpack(i_a);
    assign w_s1_e  = r_s1_op.e;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_v <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_v <= i_valid;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_s1_adv && i_valid) begin
            r_s1_op <= w_s1_in;
        end
    end

    fp_sig_align #(
        .OUT_W (OUT_W)
    ) u_align (
        .i_sig    (r_s1_op.sig),
        .i_e      (w_s1_e),
        .o_mag    (w_mag),
        .o_sticky (w_sticky)
    );

    // Negative exponents fall through the aligned path: mag=0, sticky set.
    always_comb begin
        w_s2_z     = '0;
        w_s2_flags = '0;
        case (r_s1_op.cls)
            FP_NAN: begin
                w_s2_z               = Z_MAX;
                w_s2_flags[FLAG_INV] = 1'b1;
            end
            FP_INF: begin
                w_s2_z               = r_s1_op.sign ? Z_MIN : Z_MAX;
                w_s2_flags[FLAG_OVF] = 1'b1;
            end
            FP_ZERO: begin
                w_s2_flags[FLAG_INX] = |r_s1_op.sig;
            end
            default: begin
                if (w_s1_e > E_SAT) begin
                    if (r_s1_op.sign && (w_s1_e == E_NEG_TOP) && (r_s1_op.sig[MAN_W-1:0] == '0)) begin
                        w_s2_z = Z_MIN;
                    end else begin
                        w_s2_z               = r_s1_op.sign ? Z_MIN : Z_MAX;
                        w_s2_flags[FLAG_OVF] = 1'b1;
                    end
                end else begin
                    w_s2_z               = r_s1_op.sign ? (~w_mag + 1'b1) : w_mag;
                    w_s2_flags[FLAG_INX] = w_sticky;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s2_v     <= 1'b0;
            r_s2_z     <= '0;
            r_s2_flags <= '0;
        end else if (w_s2_adv) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_s2_z     <= w_s2_z;
                r_s2_flags <= w_s2_flags;
            end
        end
    end

    a_hold_stable: assert property (@(posedge i_clk) disable iff (i_rst)
        (o_valid && !i_ready) |=> (o_valid && $stable(o_z) && $stable(o_flags)));

endmodule

// File: tb/tb_fp32_to_int_pipe.sv
// Directed-vector bench for fp32_to_int_pipe with OUT_W=32.
module tb_fp32_to_int_pipe;

    localparam int OUT_W = 32;
    localparam int NV    = 23;

    // {operand, expected result, expected {invalid, overflow, inexact}}
    localparam logic [66:0] TAB [NV] = '{
        {32'h3FC00000, 32'h00000001, 3'b001},
        {32'hC2F60000, 32'hFFFFFF85, 3'b000},
        {32'h80000000, 32'h00000000, 3'b000},
        {32'h4F000000, 32'h7FFFFFFF, 3'b010},
        {32'hCF000000, 32'h80000000, 3'b000},
        {32'h7FC00000, 32'h7FFFFFFF, 3'b100},
        {32'hFF800000, 32'h80000000, 3'b010},
        {32'h00000001, 32'h00000000, 3'b001},
        {32'h7F800000, 32'h7FFFFFFF, 3'b010},
        {32'h3F000000, 32'h00000000, 3'b001},
        {32'h4EFFFFFF, 32'h7FFFFF80, 3'b000},
        {32'hBF800000, 32'hFFFFFFFF, 3'b000},
        {32'hCF000001, 32'h80000000, 3'b010},
        {32'h4FFFFFFF, 32'h7FFFFFFF, 3'b010},
        {32'hC0490FDB, 32'hFFFFFFFD, 3'b001},
        {32'h3F7FFFFF, 32'h00000000, 3'b001},
        {32'h00000000, 32'h00000000, 3'b000},
        {32'h80400000, 32'h00000000, 3'b001},
        {32'h4B000001, 32'h00800001, 3'b000},
        {32'h4B800001, 32'h01000002, 3'b000},
        {32'hCB800001, 32'hFEFFFFFE, 3'b000},
        {32'h7F800001, 32'h7FFFFFFF, 3'b100},
        {32'hFFC00000, 32'h7FFFFFFF, 3'b100}
    };

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_valid = 1'b0;
    logic             o_ready;
    logic [31:0]      i_a = '0;
    logic             o_valid;
    logic             i_ready = 1'b1;
    logic [OUT_W-1:0] o_z;
    logic [2:0]       o_flags;

    int n_vec = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    fp32_to_int_pipe #(
        .OUT_W (OUT_W)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (i_a),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_z     (o_z),
        .o_flags (o_flags)
    );

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Drives one operand into an idle pipe and returns the first result and edges until o_valid.
    task automatic run_one(input logic [31:0] a, output logic [31:0] z, output logic [2:0] f, output int lat);
        z   = 'x;
        f   = 'x;
        lat = 99;
        step();
        i_valid = 1'b1;
        i_a     = a;
        for (int c = 1; c <= 10; c++) begin
            step();
            i_valid = 1'b0;
            #1;
            if (o_valid) begin
                z   = o_z;
                f   = o_flags;
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        step();
        step();
        #1;
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_o_valid: got %b want 0", o_valid); end
        n_vec++; if (o_z !== '0) begin n_err++; $display("FAIL reset_o_z: got %h want 0", o_z); end
        n_vec++; if (o_flags !== 3'b000) begin n_err++; $display("FAIL reset_o_flags: got %b want 000", o_flags); end
        n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset_o_ready: got %b want 1", o_ready); end
        i_rst = 1'b0;
    endtask

    task automatic test_conversions();
        logic [66:0] v;
        logic [31:0] z;
        logic [2:0]  f;
        int          lat;
        i_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            v = TAB[i];
            run_one(v[66:35], z, f, lat);
            n_vec++;
            if (z !== v[34:3]) begin
                n_err++;
                $display("FAIL conv_z[%0d] a=%h: got %h want %h", i, v[66:35], z, v[34:3]);
            end
            n_vec++;
            if (f !== v[2:0]) begin
                n_err++;
                $display("FAIL conv_flags[%0d] a=%h: got %b want %b", i, v[66:35], f, v[2:0]);
            end
            if (i == 0) begin
                n_vec++;
                if (lat != 2) begin n_err++; $display("FAIL latency: got %0d want 2", lat); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int          sent = 0;
        int          rcv = 0;
        int          last_c = -1;
        int          stalls = 0;
        logic [66:0] v;
        i_ready = 1'b1;
        for (int c = 0; c < NV + 10; c++) begin
            step();
            i_valid = (sent < NV);
            if (sent < NV) begin
                v   = TAB[sent];
                i_a = v[66:35];
            end
            #1;
            if (i_valid && !o_ready) stalls++;
            if (o_valid) begin
                if (rcv < NV) begin
                    v = TAB[rcv];
                    n_vec++;
                    if (o_z !== v[34:3] || o_flags !== v[2:0]) begin
                        n_err++;
                        $display("FAIL b2b[%0d]: got %h/%b want %h/%b", rcv, o_z, o_flags, v[34:3], v[2:0]);
                    end
                end else begin
                    n_vec++; n_err++;
                    $display("FAIL b2b_extra: got %h want no output", o_z);
                end
                rcv++;
                last_c = c;
            end
            if (i_valid && o_ready) sent++;
        end
        i_valid = 1'b0;
        n_vec++; if (rcv != NV) begin n_err++; $display("FAIL b2b_count: got %0d want %0d", rcv, NV); end
        n_vec++; if (stalls != 0) begin n_err++; $display("FAIL b2b_stalls: got %0d want 0", stalls); end
        n_vec++; if (last_c != NV + 1) begin n_err++; $display("FAIL b2b_last_cycle: got %0d want %0d", last_c, NV + 1); end
    endtask

    task automatic test_backpressure();
        logic [31:0] in_a [3];
        int          sent = 0;
        int          got = 0;
        in_a[0] = 32'h3F800000;
        in_a[1] = 32'h40000000;
        in_a[2] = 32'h40400000;
        for (int c = 0; c < 15; c++) begin
            step();
            i_ready = (c >= 4);
            i_valid = (sent < 3);
            if (sent < 3) i_a = in_a[sent];
            #1;
            if (c == 2 || c == 3) begin
                n_vec++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL bp_o_ready c%0d: got %b want 0", c, o_ready); end
                n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL bp_o_valid c%0d: got %b want 1", c, o_valid); end
                n_vec++; if (o_z !== 32'd1) begin n_err++; $display("FAIL bp_hold_z c%0d: got %h want 1", c, o_z); end
            end
            if (o_valid && i_ready) begin
                n_vec++;
                if (got >= 3) begin
                    n_err++;
                    $display("FAIL bp_duplicate: got %h want no output", o_z);
                end else if (o_z !== 32'(got + 1) || o_flags !== 3'b000) begin
                    n_err++;
                    $display("FAIL bp_order[%0d]: got %h/%b want %h/000", got, o_z, o_flags, got + 1);
                end
                got++;
            end
            if (i_valid && o_ready) sent++;
        end
        i_valid = 1'b0;
        n_vec++; if (got != 3) begin n_err++; $display("FAIL bp_count: got %0d want 3", got); end
        n_vec++; if (sent != 3) begin n_err++; $display("FAIL bp_accepts: got %0d want 3", sent); end
    endtask

    task automatic test_reset_midstream();
        int          stale = 0;
        logic [31:0] z;
        logic [2:0]  f;
        int          lat;
        i_ready = 1'b0;
        step();
        i_valid = 1'b1;
        i_a     = 32'h3F800000;
        step();
        i_a     = 32'h40000000;
        step();
        i_valid = 1'b0;
        #1;
        n_vec++; if (o_ready !== 1'b0 || o_valid !== 1'b1) begin
            n_err++; $display("FAIL mid_full: got ready=%b valid=%b want ready=0 valid=1", o_ready, o_valid);
        end
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        #1;
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", o_valid); end
        n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_ready: got %b want 1", o_ready); end
        i_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            #1;
            if (o_valid) stale++;
        end
        n_vec++; if (stale != 0) begin n_err++; $display("FAIL mid_stale: got %0d outputs want 0", stale); end
        run_one(32'h40400000, z, f, lat);
        n_vec++; if (z !== 32'd3 || f !== 3'b000) begin
            n_err++; $display("FAIL mid_recover: got %h/%b want 00000003/000", z, f);
        end
    endtask

    initial begin
        test_reset();
        test_conversions();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
